// File: rtl/decode_stage_ctrl_if.sv
// Fetch/decode/execute handshake bundle around the IF/ID holding register.
// Registered data with zero-cycle issue; backpressure comes from ex_ready and the load-use hazard.
interface decode_stage_ctrl_if #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5
);
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [INSTR_W-1:0] if_pc;
  logic               id_ready;
  logic               id_valid;
  logic               ex_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [INSTR_W-1:0] id_pc;
  logic               ex_mem_read;
  logic [REG_AW-1:0]  ex_rd;
  logic               flush;
  logic               id_stall;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, ex_mem_read, ex_rd, flush,
    input  id_ready, id_valid, id_instr, id_pc, id_stall
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, ex_mem_read, ex_rd, flush,
    output id_ready, id_valid, id_instr, id_pc, id_stall
  );
endinterface

// File: rtl/decode_stage_ctrl.sv
// Single-entry IF/ID holding register with load-use stall and flush; optional perf counters under DECODE_CTRL_PERF_EN.
// Latency: capture 1 cycle, issue 0 cycles after capture; stalls on ex_ready=0 or load-use hazard, flush wins over all.
module decode_stage_ctrl #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  decode_stage_ctrl_if.slave  bus
`ifdef DECODE_CTRL_PERF_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pc_q;
  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic               hazard;
  logic               valid;
  logic               stall;
  logic               ready;
  logic               capture;
  logic               issue;

  assign rs = instr_q[21 +: REG_AW];
  assign rt = instr_q[16 +: REG_AW];

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = (state != EMPTY) && bus.ex_mem_read && (bus.ex_rd != '0) &&
                  ((bus.ex_rd == rs) || (bus.ex_rd == rt));

  assign capture = bus.if_valid && ready;
  assign issue   = valid && bus.ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (capture) state_nxt = FULL;
        FULL, STALL: begin
          if (hazard)     state_nxt = STALL;
          else if (issue) state_nxt = capture ? FULL : EMPTY;
          else            state_nxt = FULL;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Reset forces the handshake quiet so nothing moves in the reset cycle.
  always_comb begin
    valid = 1'b0;
    stall = 1'b0;
    ready = 1'b0;
    if (!rst) begin
      valid = (state != EMPTY) && !hazard && !bus.flush;
      stall = (state != EMPTY) && hazard && !bus.flush;
      ready = !bus.flush && ((state == EMPTY) || (valid && bus.ex_ready));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (capture) begin
      instr_q <= bus.if_instr;
      pc_q    <= bus.if_pc;
    end
  end

  assign bus.id_valid = valid;
  assign bus.id_stall = stall;
  assign bus.id_ready = ready;
  assign bus.id_instr = instr_q;
  assign bus.id_pc    = pc_q;

`ifdef DECODE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (bus.flush && (state != EMPTY) && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/decode_stage_ctrl.md
DECODE_STAGE_CTRL -- requirements
Module: decode_stage_ctrl

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, meaning instruction and PC width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port if_valid  input  1  meaning the fetch stage offers an instruction.
REQ-006 SHALL have port if_instr  input  INSTR_W  meaning the fetched instruction.
REQ-007 SHALL have port if_pc  input  INSTR_W  meaning the fetched instruction's PC.
REQ-008 SHALL have port id_ready  output  1  meaning decode can accept from fetch.
REQ-009 SHALL have port id_valid  output  1  meaning the held instruction is issued to the instruction_decoder/ID-EX register.
REQ-010 SHALL have port ex_ready  input  1  meaning ID/EX accepts this cycle.
REQ-011 SHALL have port id_instr  output  INSTR_W  meaning the held instruction, driven to instruction_decoder.
REQ-012 SHALL have port id_pc  output  INSTR_W  meaning the held PC.
REQ-013 SHALL have port ex_mem_read  input  1  meaning the instruction in EX is a load.
REQ-014 SHALL have port ex_rd  input  REG_AW  meaning the destination register of the instruction in EX.
REQ-015 SHALL have port flush  input  1  meaning branch/jump redirect; discard decode contents.
REQ-016 SHALL have port id_stall  output  1  meaning a load-use stall is active this cycle.

Function
REQ-017 SHALL implement a single-entry IF/ID holding register with states EMPTY, FULL, STALL.
REQ-018 SHALL compute rs = id_instr[25:21] and rt = id_instr[20:16].
REQ-019 SHALL assert hazard (combinational) when the state is not EMPTY, ex_mem_read=1, ex_rd!=0, and ex_rd equals rs or rt.
REQ-020 SHALL drive id_valid = (state!=EMPTY) & !hazard & !flush.
REQ-021 SHALL drive id_stall = (state!=EMPTY) & hazard & !flush.
REQ-022 SHALL drive id_ready = !flush & (state==EMPTY | (id_valid & ex_ready)).
REQ-023 SHALL capture if_instr/if_pc into id_instr/id_pc when if_valid & id_ready; capture latency is 1 cycle and issue latency is 0 cycles after capture.
REQ-024 SHALL take these transitions:
- EMPTY->FULL on capture.
- FULL->STALL on hazard.
- STALL->FULL when hazard clears.
- FULL->EMPTY on issue (id_valid & ex_ready) with no capture.
- FULL->FULL on simultaneous issue and capture (back-to-back, no bubble).
REQ-025 SHALL hold id_instr/id_pc unchanged while in STALL, or in FULL with ex_ready=0.
REQ-026 SHALL give flush priority over capture, issue and stall: next state EMPTY, if_instr that cycle discarded, id_valid=0 that cycle.
REQ-027 SHALL treat ex_rd=0 as no hazard (register 0 is hardwired).
REQ-028 SHALL allow a hazard to persist any number of cycles, with no timeout.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state EMPTY, id_instr=0, id_pc=0, and the counters (if present) to 0.
REQ-030 SHALL, while rst=1, drive id_valid=0, id_stall=0 and id_ready=0, overriding every other input.
REQ-031 SHALL, on reset asserted mid-stall or mid-transfer, discard the held instruction; no issue occurs in the reset cycle.

Configuration
REQ-032 SHALL, when DECODE_CTRL_PERF_EN is defined, add outputs stall_cnt[15:0] and flush_cnt[15:0]:
- stall_cnt increments each cycle id_stall=1.
- flush_cnt increments each cycle flush=1 while the state is not EMPTY.
- Both counters saturate at 16'hFFFF.
REQ-033 SHALL, when DECODE_CTRL_PERF_EN is undefined, omit both counter ports and logic, with identical remaining behaviour.

Verification
REQ-034 SHALL cover streaming: if_valid=1 with instrs 0x00221820 and 0x00853020 on consecutive cycles, ex_ready=1 -> id_valid=1 for 2 consecutive cycles, id_pc sequence 0x0, 0x4, id_ready never 0.
REQ-035 SHALL cover load-use: hold 0x00221820 (rs=1, rt=2), ex_mem_read=1, ex_rd=2 for 1 cycle -> id_stall=1, id_valid=0, id_ready=0 one cycle, then issue next cycle with id_instr unchanged.
REQ-036 SHALL cover the r0 exemption: ex_mem_read=1, ex_rd=0, instr 0x00001020 -> no stall, issue immediately.
REQ-037 SHALL cover flush during stall: flush=1 while in STALL with if_valid=1 -> next cycle state EMPTY, id_valid=0, fetched instr not captured.
REQ-038 SHALL cover backpressure: ex_ready=0 for 3 cycles while FULL -> id_valid=1 held, id_instr stable, id_ready=0, then transfer on ex_ready=1.
REQ-039 SHALL cover reset mid-stall and counter saturation: rst=1 mid-stall -> all outputs 0 next cycle; with DECODE_CTRL_PERF_EN, 70000 stall cycles -> stall_cnt=16'hFFFF.
